// File: rtl/burst_ram_arbiter_pkg.sv
// Shared types and constants for the two-port BurstRAM arbiter.
package burst_ram_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGranted,
        StRead,
        StWrite,
        StRelease
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    function automatic logic [1:0] port_onehot(input logic port);
        return (port == PORT1) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/burst_ram_arbiter_rr_arbiter2.sv
// Two-input round-robin pick: on a tie the port that did not win last time is chosen.
module burst_ram_arbiter_rr_arbiter2
    import burst_ram_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_pick
);

    always_comb begin
        o_valid = |i_req;
        unique case (i_req)
            2'b01:   o_pick = PORT0;
            2'b10:   o_pick = PORT1;
            2'b11:   o_pick = ~i_last;
            default: o_pick = PORT0;
        endcase
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one BurstRAM command/data port between the I-cache (port 0) and D-cache (port 1),
// holding the grant for a full read or write burst.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64,
    parameter int unsigned RAM_BURST_DATA_COUNT    = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,

    input  logic                                 m0_req,
    output logic                                 m0_gnt,
    input  logic                                 m0_cmd,
    input  logic                                 m0_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        m0_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m0_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m0_data_mask,
    output logic                                 m0_rd_data_valid,

    input  logic                                 m1_req,
    output logic                                 m1_gnt,
    input  logic                                 m1_cmd,
    input  logic                                 m1_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0]        m1_addr,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   m1_wr_data,
    input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] m1_data_mask,
    output logic                                 m1_rd_data_valid,

    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   rd_data,

    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy,

    output logic                                 err
);

    localparam int unsigned CNT_W = $clog2(RAM_BURST_DATA_COUNT) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RAM_BURST_DATA_COUNT - 1);

    state_e           r_state, w_state_d;
    logic             r_owner, w_owner_d;
    logic             r_last,  w_last_d;
    logic [CNT_W-1:0] r_cnt,   w_cnt_d;
    logic             r_err,   w_err_d;

    logic [1:0] w_req, w_cmd_en, w_cmd, w_cmd_slot, w_gnt;
    logic       w_own_req, w_own_cmd_en, w_own_cmd;
    logic       w_granted, w_violation;
    logic       w_arb_valid, w_arb_pick;

    assign w_req    = {m1_req, m0_req};
    assign w_cmd_en = {m1_cmd_en, m0_cmd_en};
    assign w_cmd    = {m1_cmd, m0_cmd};

    assign w_own_req    = w_req[r_owner];
    assign w_own_cmd_en = w_cmd_en[r_owner];
    assign w_own_cmd    = w_cmd[r_owner];
    assign w_granted    = r_state inside {StGranted, StRead, StWrite};

    burst_ram_arbiter_rr_arbiter2 u_rr_arbiter2 (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_valid (w_arb_valid),
        .o_pick  (w_arb_pick)
    );

    // Only the owner's cmd_en during GRANTED is legal; everything else is a protocol error.
    assign w_cmd_slot  = (r_state == StGranted) ? port_onehot(r_owner) : 2'b00;
    assign w_violation = (|(w_cmd_en & ~w_cmd_slot)) | (br_rd_data_valid & (r_state != StRead));
    assign w_err_d     = r_err | w_violation;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_owner <= PORT0;
            r_last  <= PORT1;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_owner <= w_owner_d;
            r_last  <= w_last_d;
            r_cnt   <= w_cnt_d;
            r_err   <= w_err_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_owner_d = r_owner;
        w_last_d  = r_last;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (!br_busy && w_arb_valid) begin
                    w_state_d = StGranted;
                    w_owner_d = w_arb_pick;
                    w_last_d  = w_arb_pick;
                end
            end
            StGranted: begin
                if (w_own_cmd_en) begin
                    unique case (w_own_cmd)
                        CMD_READ: begin
                            w_state_d = StRead;
                            w_cnt_d   = '0;
                        end
                        CMD_WRITE: begin
                            // The cmd_en cycle already carries beat 0.
                            w_state_d = (RAM_BURST_DATA_COUNT == 1) ? StRelease : StWrite;
                            w_cnt_d   = CNT_W'(1);
                        end
                        default: w_state_d = StIdle;
                    endcase
                end else if (!w_own_req) begin
                    w_state_d = StIdle;
                end
            end
            StRead: begin
                if (br_rd_data_valid) begin
                    if (r_cnt == LAST_BEAT) w_state_d = StRelease;
                    else                    w_cnt_d   = r_cnt + CNT_W'(1);
                end
            end
            StWrite: begin
                if (r_cnt == LAST_BEAT) w_state_d = StRelease;
                else                    w_cnt_d   = r_cnt + CNT_W'(1);
            end
            StRelease: w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_gnt        = w_granted ? port_onehot(r_owner) : 2'b00;
        m0_gnt       = w_gnt[0];
        m1_gnt       = w_gnt[1];
        br_cmd       = 1'b0;
        br_addr      = '0;
        br_wr_data   = '0;
        br_data_mask = '0;
        if (w_granted) begin
            if (r_owner == PORT1) begin
                br_cmd       = m1_cmd;
                br_addr      = m1_addr;
                br_wr_data   = m1_wr_data;
                br_data_mask = m1_data_mask;
            end else begin
                br_cmd       = m0_cmd;
                br_addr      = m0_addr;
                br_wr_data   = m0_wr_data;
                br_data_mask = m0_data_mask;
            end
        end
        br_cmd_en        = (r_state == StGranted) & w_own_cmd_en;
        m0_rd_data_valid = br_rd_data_valid & (r_state == StRead) & (r_owner == PORT0);
        m1_rd_data_valid = br_rd_data_valid & (r_state == StRead) & (r_owner == PORT1);
        rd_data          = br_rd_data;
        err              = r_err;
    end

endmodule
